// File: rtl/cskip_burst_accumulator.sv
// Sums fixed-length bursts of 17-bit carry-skip adder results into a wide total.
// Each finished total waits in a one-deep output slot while the next burst accumulates.
`timescale 1ns/1ps
module cskip_burst_accumulator #(
   parameter int BURST = 4,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_sum,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic             out_ovf,
   output logic [15:0]      bursts_done
);

   localparam logic [7:0] LAST = 8'(BURST - 1);

   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             ovf_acc;
   logic [ACC_W-1:0] operand;
   logic [ACC_W:0]   sum_ext;
   logic             last;
   logic             accept;
   logic             complete;

   assign operand  = {{(ACC_W - 17){1'b0}}, in_cout, in_sum};
   assign sum_ext  = {1'b0, acc} + {1'b0, operand};
   assign last     = (cnt == LAST);

   // Only the element that would finish a burst can stall, and only when the slot stays full.
   assign in_ready = !clr && !(last && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;
   assign complete = accept && last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf_acc <= 1'b0;
      end else if (clr || complete) begin
         acc     <= '0;
         cnt     <= '0;
         ovf_acc <= 1'b0;
      end else if (accept) begin
         acc     <= sum_ext[ACC_W-1:0];
         cnt     <= cnt + 8'd1;
         ovf_acc <= ovf_acc | sum_ext[ACC_W];
      end
   end

   // A completing accept reloads the slot even while it drains, so out_valid stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_total   <= '0;
         out_ovf     <= 1'b0;
         bursts_done <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (complete) begin
         out_valid   <= 1'b1;
         out_total   <= sum_ext[ACC_W-1:0];
         out_ovf     <= ovf_acc | sum_ext[ACC_W];
         bursts_done <= bursts_done + 16'd1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cskip_burst_accumulator.sv
// Directed bench for cskip_burst_accumulator: default instance plus an ACC_W=18 instance
// sharing the same stimulus so wrap-around can be seen on the narrow total.
`timescale 1ns/1ps
module tb_cskip_burst_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_sum = '0;
   logic        in_cout = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_ovf;
   logic [23:0] out_total;
   logic [15:0] bursts_done;

   logic        in_ready18, out_valid18, out_ovf18;
   logic [17:0] out_total18;
   logic [15:0] bursts_done18;

   int errors = 0;
   int checks = 0;

   cskip_burst_accumulator dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_cout(in_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_total(out_total), .out_ovf(out_ovf),
      .bursts_done(bursts_done)
   );

   cskip_burst_accumulator #(.BURST(4), .ACC_W(18)) dut18 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready18),
      .in_sum(in_sum), .in_cout(in_cout),
      .out_valid(out_valid18), .out_ready(out_ready),
      .out_total(out_total18), .out_ovf(out_ovf18),
      .bursts_done(bursts_done18)
   );

   always #5 clk = ~clk;

   // Leaves the bench 1 time unit after a rising edge with both instances freshly reset.
   task automatic do_reset();
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b0;
      in_sum    = '0;
      in_cout   = 1'b0;
      rst       = 1'b1;
      #7;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic cout, input logic [15:0] sum);
      in_valid = 1'b1;
      in_cout  = cout;
      in_sum   = sum;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_total !== 24'h0) begin errors++; $display("[TB] FAIL reset_out_total got %h want 000000", out_total); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf got %b want 0", out_ovf); end
      checks++; if (bursts_done !== 16'h0) begin errors++; $display("[TB] FAIL reset_bursts_done got %h want 0000", bursts_done); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic_burst();
      do_reset();
      out_ready = 1'b1;
      send(1'b0, 16'h0001);
      send(1'b0, 16'h0002);
      send(1'b0, 16'h0003);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %b want 0", out_valid); end
      send(1'b1, 16'h0000);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); end
      checks++; if (out_total !== 24'h010006) begin errors++; $display("[TB] FAIL basic_out_total got %h want 010006", out_total); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_out_ovf got %b want 0", out_ovf); end
      checks++; if (bursts_done !== 16'd1) begin errors++; $display("[TB] FAIL basic_bursts_done got %0d want 1", bursts_done); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain got %b want 0", out_valid); end
   endtask

   task automatic test_ovf_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(1'b1, 16'hFFFF);
      checks++; if (out_total18 !== 18'h3FFFC) begin errors++; $display("[TB] FAIL wrap_total18 got %h want 3fffc", out_total18); end
      checks++; if (out_ovf18 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ovf18 got %b want 1", out_ovf18); end
      checks++; if (out_total !== 24'h07FFFC) begin errors++; $display("[TB] FAIL wrap_total24 got %h want 07fffc", out_total); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf24 got %b want 0", out_ovf); end
      for (int i = 0; i < 4; i++) send(1'b0, 16'h0001);
      checks++; if (out_total18 !== 18'h4) begin errors++; $display("[TB] FAIL wrap_next_total18 got %h want 00004", out_total18); end
      checks++; if (out_ovf18 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_next_ovf18 got %b want 0", out_ovf18); end
      checks++; if (bursts_done18 !== 16'd2) begin errors++; $display("[TB] FAIL wrap_bursts18 got %0d want 2", bursts_done18); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_cout   = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         in_sum = 16'(i);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_elem%0d got %b want 1", i, in_ready); end
         @(posedge clk);
         #1;
         if (i == 4) begin
            checks++; if (out_total !== 24'd10) begin errors++; $display("[TB] FAIL bp_first_total got %0d want 10", out_total); end
         end
      end
      in_sum = 16'd8;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready got %b want 0", in_ready); end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid got %b want 1", out_valid); end
      checks++; if (out_total !== 24'd10) begin errors++; $display("[TB] FAIL bp_hold_total got %0d want 10", out_total); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_pulse_ready got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_valid got %b want 1", out_valid); end
      checks++; if (out_total !== 24'd26) begin errors++; $display("[TB] FAIL bp_second_total got %0d want 26", out_total); end
      checks++; if (bursts_done !== 16'd2) begin errors++; $display("[TB] FAIL bp_bursts got %0d want 2", bursts_done); end
   endtask

   task automatic test_clear();
      do_reset();
      out_ready = 1'b1;
      send(1'b0, 16'h0100);
      send(1'b0, 16'h0100);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_sum   = 16'h0100;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_in_ready got %b want 0", in_ready); end
      @(posedge clk);
      #1;
      checks++; if (bursts_done !== 16'd0) begin errors++; $display("[TB] FAIL clr_bursts got %0d want 0", bursts_done); end
      clr      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) send(1'b0, 16'h0001);
      checks++; if (out_total !== 24'd4) begin errors++; $display("[TB] FAIL clr_total got %h want 000004", out_total); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_valid got %b want 1", out_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(1'b0, 16'h0001);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_valid got %b want 1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid got %b want 0", out_valid); end
      checks++; if (out_total !== 24'h0) begin errors++; $display("[TB] FAIL arst_total got %h want 000000", out_total); end
      checks++; if (bursts_done !== 16'h0) begin errors++; $display("[TB] FAIL arst_bursts got %0d want 0", bursts_done); end
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(1'b0, 16'(i));
      checks++; if (out_total !== 24'd10) begin errors++; $display("[TB] FAIL arst_fresh_total got %0d want 10", out_total); end
      checks++; if (bursts_done !== 16'd1) begin errors++; $display("[TB] FAIL arst_fresh_bursts got %0d want 1", bursts_done); end
   endtask

   initial begin
      test_reset();
      test_basic_burst();
      test_ovf_wrap();
      test_back_to_back();
      test_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
